// File: rtl/stream_rr_mux_if.sv
// Stream bundle for stream_rr_mux: NUM_CH producer channels in,
// one registered consumer channel out.
interface stream_rr_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch
    );
endinterface

// File: rtl/stream_rr_mux.sv
// N:1 valid/ready stream mux with a one-entry registered output.
// Fixed-select or round-robin arbitration; no bubble when draining.
module stream_rr_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    stream_rr_mux_if.slave   bus
);
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic [SEL_W-1:0]  rr_q, rr_d;
    logic              gnt_vld;
    logic [SEL_W-1:0]  gnt_ch;
    logic              load_en;
    logic [DATA_W-1:0] ch_data [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_data[i] = bus.in_data[i*DATA_W +: DATA_W];
    end

    assign load_en = !out_valid_q || bus.out_ready;

    always_comb begin : arb
        int               idx;
        logic [SEL_W-1:0] cand;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        idx     = 0;
        cand    = '0;
        if (mode) begin
            // scan starting at rr_q, wrapping modulo NUM_CH
            for (int k = 0; k < NUM_CH; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end
                cand = SEL_W'(idx);
                if (!gnt_vld && bus.in_valid[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = cand;
                end
            end
        end else if (int'(sel) < NUM_CH && bus.in_valid[sel]) begin
            gnt_vld = 1'b1;
            gnt_ch  = sel;
        end
    end

    always_comb begin : rdy
        bus.in_ready = '0;
        if (rst_n && gnt_vld && load_en) begin
            bus.in_ready[gnt_ch] = 1'b1;
        end
    end

    always_comb begin : nxt
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_d        = rr_q;
        if (load_en) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d = ch_data[gnt_ch];
                out_ch_d   = gnt_ch;
                if (mode) begin
                    rr_d = (int'(gnt_ch) == NUM_CH - 1) ? '0 : gnt_ch + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_q        <= rr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_rr_mux.sv
// Bench for stream_rr_mux: vector table for arbitration/handshake,
// scoreboard on the output stream, hand sequences for corner cases.
module tb_stream_rr_mux;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [7:0] base;
        logic [3:0] exp_rdy;
        logic       exp_ov;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
    } word_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] sel = 2'd0;
    int         checks = 0;
    int         failures = 0;
    word_t      sbq[$];
    vec_t       tbl[15];

    stream_rr_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    stream_rr_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic m, input logic [1:0] s,
                         input logic [3:0] v, input logic r,
                         input logic [7:0] base, input logic [3:0] er,
                         input logic eov);
        mode = m;
        sel = s;
        bus.in_valid = v;
        bus.out_ready = r;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.in_data[i*DATA_W +: DATA_W] = base + 8'(i);
        end
        @(negedge clk);
        chk("in_ready", 32'(bus.in_ready), 32'(er));
        chk("out_valid", 32'(bus.out_valid), 32'(eov));
        for (int i = 0; i < NUM_CH; i++) begin
            if (er[i]) begin
                sbq.push_back('{base + 8'(i), 2'(i)});
            end
        end
    endtask

    always @(negedge clk) begin : mon
        word_t w;
        if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty: got data %0h ch %0d expected none",
                         bus.out_data, bus.out_ch);
            end else begin
                w = sbq.pop_front();
                chk("sb_data", 32'(bus.out_data), 32'(w.data));
                chk("sb_ch", 32'(bus.out_ch), 32'(w.ch));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 8'hA3, 4'b0100, 1'b0};
        tbl[1]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 8'h50, 4'b0000, 1'b1};
        tbl[2]  = '{1'b0, 2'd1, 4'b0000, 1'b0, 8'h60, 4'b0000, 1'b0};
        tbl[3]  = '{1'b1, 2'd0, 4'b0010, 1'b0, 8'h70, 4'b0010, 1'b0};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 8'h80, 4'b0000, 1'b1};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 8'h90, 4'b0100, 1'b1};
        tbl[6]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 8'hB0, 4'b0001, 1'b1};
        tbl[7]  = '{1'b1, 2'd0, 4'b0001, 1'b1, 8'hC0, 4'b0001, 1'b1};
        tbl[8]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 8'hD0, 4'b1000, 1'b1};
        tbl[9]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 8'hE0, 4'b0001, 1'b1};
        tbl[10] = '{1'b1, 2'd0, 4'b1001, 1'b1, 8'hF0, 4'b1000, 1'b1};
        tbl[11] = '{1'b1, 2'd0, 4'b1001, 1'b1, 8'h00, 4'b0001, 1'b1};
        tbl[12] = '{1'b1, 2'd0, 4'b0000, 1'b1, 8'h10, 4'b0000, 1'b1};
        tbl[13] = '{1'b1, 2'd0, 4'b1000, 1'b1, 8'h20, 4'b1000, 1'b0};
        tbl[14] = '{1'b1, 2'd0, 4'b0000, 1'b1, 8'h30, 4'b0000, 1'b1};

        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.in_data[i*DATA_W +: DATA_W] = 8'hA0 + 8'(i);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].mode, tbl[i].sel, tbl[i].valid, tbl[i].ordy,
                  tbl[i].base, tbl[i].exp_rdy, tbl[i].exp_ov);
            tick();
        end

        for (int k = 0; k < 8; k++) begin
            apply(1'b1, 2'd0, 4'b1111, 1'b1, 8'(8'h05 + k * 16),
                  4'(1 << (k % 4)), k > 0);
            tick();
        end

        apply(1'b0, 2'd2, 4'b0100, 1'b1, 8'h3A, 4'b0100, 1'b1);
        tick();
        for (int j = 0; j < 3; j++) begin
            apply(1'b1, 2'(j), 4'b1111, 1'b0, 8'(8'h71 + j * 16),
                  4'b0000, 1'b1);
            chk("bp_data", 32'(bus.out_data), 32'h3C);
            chk("bp_ch", 32'(bus.out_ch), 32'd2);
            tick();
        end
        apply(1'b1, 2'd0, 4'b1111, 1'b1, 8'h40, 4'b0001, 1'b1);
        tick();
        apply(1'b1, 2'd0, 4'b0000, 1'b1, 8'h00, 4'b0000, 1'b1);
        tick();
        apply(1'b1, 2'd0, 4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0);
        tick();

        apply(1'b0, 2'd1, 4'b0010, 1'b0, 8'h50, 4'b0010, 1'b0);
        tick();
        rst_n = 1'b0;
        bus.in_valid = 4'b1111;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_held", 32'(bus.out_data), 32'h51);
        tick();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_data", 32'(bus.out_data), 32'd0);
        chk("mid_rst_ch", 32'(bus.out_ch), 32'd0);
        sbq.delete();
        rst_n = 1'b1;
        repeat (2) begin
            apply(1'b0, 2'd0, 4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0);
            tick();
        end
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
